// File: rtl/adc_dac_sequencer.sv
// ---------------------------------------------------------------------------
// adc_dac_sequencer
//
// Per-sample scheduler for the ADC -> DAC/PWM datapath. A free-running
// divider produces a sample tick. On each tick the sequencer converts the
// enabled channels in order (CH0 first, then CH1) through spi2adc and latches
// each result. It then drives one dac_load pulse per frame with the selected
// channel's sample. Ticks that arrive mid-frame and conversions that never
// complete are reported through sticky flags.
//
// Parameters
//   CLK_DIV  sysclk cycles per sample tick (2..65535)
//   TIMEOUT  cycles spent waiting for adc_valid before a conversion is dropped
//
// Ports
//   sysclk       in   system clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   enable       in   run divider / allow new frames (0 holds divider at 0)
//   ch_mask[1:0] in   bit0 = sample CH0, bit1 = sample CH1
//   dac_src      in   channel that feeds dac_data (0 = CH0, 1 = CH1)
//   clr_err      in   synchronous clear of overrun / timeout_err
//   adc_start    out  one-cycle start pulse to spi2adc
//   adc_channel  out  channel select to spi2adc
//   adc_data     in   conversion result from spi2adc
//   adc_valid    in   data_valid level from spi2adc (rising edge = event)
//   ch0_sample   out  last good CH0 result
//   ch1_sample   out  last good CH1 result
//   dac_data     out  word to spi2dac / pwm
//   dac_load     out  one-cycle load pulse to spi2dac / pwm
//   sample_tick  out  one-cycle divider tick
//   busy         out  high whenever the sequencer is not idle
//   overrun      out  sticky: a tick arrived while busy
//   timeout_err  out  sticky: a conversion timed out
// ---------------------------------------------------------------------------
module adc_dac_sequencer #(
  parameter int CLK_DIV = 5000,
  parameter int TIMEOUT = 1023
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] ch_mask,
  input  logic       dac_src,
  input  logic       clr_err,
  output logic       adc_start,
  output logic       adc_channel,
  input  logic [9:0] adc_data,
  input  logic       adc_valid,
  output logic [9:0] ch0_sample,
  output logic [9:0] ch1_sample,
  output logic [9:0] dac_data,
  output logic       dac_load,
  output logic       sample_tick,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_STORE,
    ST_LOAD
  } state_t;

  state_t            state;
  state_t            state_d;
  logic              channel;
  logic              channel_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic [15:0]       div_cnt;
  logic              adc_valid_q;
  logic              vld_rise;
  logic              store_en;
  logic              tmo_set;
  logic              overrun_set;
  logic              go_ch1;
  logic [9:0]        dac_sel;
  logic [9:0]        dac_hold;

  // Sample-rate divider: counts 0..CLK_DIV-1 while enabled. Dropping enable
  // parks it at 0, so the first tick after re-enabling is a full period away.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign sample_tick = enable && (div_cnt == DIV_LAST);

  // Delayed copy of adc_valid. It is used only to find the rising edge, because
  // spi2adc holds data_valid high for more than one cycle.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      adc_valid_q <= 1'b0;
    end else begin
      adc_valid_q <= adc_valid;
    end
  end

  assign vld_rise = adc_valid & ~adc_valid_q;

  // FSM state, current channel and WAIT-state cycle counter.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      channel  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      channel  <= channel_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // After a channel finishes (stored or timed out), CH1 follows CH0 only if
  // CH1 is still enabled at that moment. Otherwise the frame goes to LOAD.
  assign go_ch1 = !channel && ch_mask[1];

  // Next-state logic. The first channel of a frame is the lowest set mask bit.
  // A timeout takes the same next-channel decision as a normal store, but does
  // not write to the sample register.
  always_comb begin
    state_d    = state;
    channel_d  = channel;
    wait_cnt_d = wait_cnt;
    store_en   = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_tick && (ch_mask != 2'b00)) begin
          state_d   = ST_START;
          channel_d = ~ch_mask[0];
        end
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (vld_rise) begin
          state_d = ST_STORE;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo_set = 1'b1;
          if (go_ch1) begin
            channel_d = 1'b1;
            state_d   = ST_START;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        if (go_ch1) begin
          channel_d = 1'b1;
          state_d   = ST_START;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign adc_start   = (state == ST_START);
  assign dac_load    = (state == ST_LOAD);
  assign busy        = (state != ST_IDLE);
  assign adc_channel = channel;

  // Per-channel result registers. They change only on a successful conversion,
  // so a timed-out channel keeps its previous good value.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      ch0_sample <= '0;
      ch1_sample <= '0;
    end else if (store_en) begin
      if (channel) begin
        ch1_sample <= adc_data;
      end else begin
        ch0_sample <= adc_data;
      end
    end
  end

  // dac_data must already be valid in the LOAD cycle, including a sample that
  // was written in the STORE cycle just before. So during LOAD it shows the
  // live selection. That selection is also captured so that dac_data stays
  // stable between loads.
  assign dac_sel  = dac_src ? ch1_sample : ch0_sample;
  assign dac_data = dac_load ? dac_sel : dac_hold;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      dac_hold <= '0;
    end else if (state == ST_LOAD) begin
      dac_hold <= dac_sel;
    end
  end

  // Sticky error flags. A set event wins over clr_err in the same cycle, so
  // an error is never lost.
  assign overrun_set = sample_tick && (state != ST_IDLE);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (tmo_set) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
